// File: rtl/cordic_sincos_iter.sv
// cordic_sincos_iter: iterative rotation-mode CORDIC that produces cos(theta)
// and sin(theta) together, one micro-rotation per clock.
//
// The angle input uses 16-bit binary angle units (0x4000 = +90 deg). Angles
// beyond +/-90 deg are folded into the convergence range by a 180 deg
// pre-rotation, and the result is negated on the way out.
//
// x/y carry two guard bits above the DW-bit output format, so intermediate
// growth can be absorbed before the final saturation.
//
// Optional build macro: CORDIC_VECTOR_EN
//   When defined, the ports mode, x_in and y_in are added. mode=1 at start
//   runs vectoring mode: cos_out returns the gain-scaled magnitude and
//   sin_out returns the accumulated angle. Without the macro the block is
//   rotation-only.
module cordic_sincos_iter #(
  parameter int DW     = 16,
  parameter int ITER   = 16,
  parameter int X_INIT = 9949
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   theta,
`ifdef CORDIC_VECTOR_EN
  input  logic          mode,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
`endif
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] cos_out,
  output logic [DW-1:0] sin_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [3:0]           ITER_LAST = 4'(ITER - 1);
  localparam logic signed [DW+1:0] X0        = X_INIT[DW+1:0];

  // arctan(2^-i) in binary angle units; entries past ITER-1 are never used
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    logic [15:0] a;
    case (idx)
      4'd0:    a = 16'd8192;
      4'd1:    a = 16'd4836;
      4'd2:    a = 16'd2555;
      4'd3:    a = 16'd1297;
      4'd4:    a = 16'd651;
      4'd5:    a = 16'd326;
      4'd6:    a = 16'd163;
      4'd7:    a = 16'd81;
      4'd8:    a = 16'd41;
      4'd9:    a = 16'd20;
      4'd10:   a = 16'd10;
      4'd11:   a = 16'd5;
      4'd12:   a = 16'd3;
      4'd13:   a = 16'd1;
      4'd14:   a = 16'd1;
      4'd15:   a = 16'd0;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

  // Clamp a guard-extended value into the signed DW-bit output range.
  // The value fits when its top three bits all agree.
  function automatic logic [DW-1:0] sat_dw(input logic signed [DW+1:0] v);
    logic [DW-1:0] r;
    if ((v[DW+1:DW-1] == 3'b000) || (v[DW+1:DW-1] == 3'b111)) begin
      r = v[DW-1:0];
    end else if (v[DW+1]) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r = {1'b0, {(DW-1){1'b1}}};
    end
    return r;
  endfunction

`ifdef CORDIC_VECTOR_EN
  localparam int ZSH = (DW < 16) ? (16 - DW) : 0;

  // Angle output for vectoring: keep the top DW bits when DW < 16,
  // otherwise sign-extend the 16-bit angle.
  function automatic logic [DW-1:0] z_to_dw(input logic [15:0] z);
    logic signed [39:0] ext;
    logic signed [39:0] shf;
    ext = {{24{z[15]}}, z};
    shf = ext >>> ZSH;
    return shf[DW-1:0];
  endfunction
`endif

  state_t               state_q, state_d;
  logic [3:0]           iter_q, iter_d;
  logic signed [DW+1:0] x_q, x_d;
  logic signed [DW+1:0] y_q, y_d;
  logic [15:0]          z_q, z_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DW-1:0]        cos_q, cos_d;
  logic [DW-1:0]        sin_q, sin_d;

  logic signed [DW+1:0] x_sh_s, y_sh_s;
  logic signed [DW+1:0] x_fin_s, y_fin_s;
  logic                 dir_s;
  logic                 quad_s;
  logic                 vec_s;

`ifdef CORDIC_VECTOR_EN
  logic                 vec_q, vec_d;
  logic signed [DW+1:0] x_ext_s, y_ext_s;
  assign x_ext_s = {{2{x_in[DW-1]}}, x_in};
  assign y_ext_s = {{2{y_in[DW-1]}}, y_in};
  assign vec_s   = vec_q;
`else
  assign vec_s   = 1'b0;
`endif

  // Shifted operands, rotation direction, quadrant fold and final sign fix-up
  always_comb begin
    x_sh_s  = x_q >>> iter_q;
    y_sh_s  = y_q >>> iter_q;
    quad_s  = theta[15] ^ theta[14];
    if (vec_s) begin
      dir_s = ~y_q[DW+1];
    end else begin
      dir_s = z_q[15];
    end
    if (neg_q) begin
      x_fin_s = -x_q;
      y_fin_s = -y_q;
    end else begin
      x_fin_s = x_q;
      y_fin_s = y_q;
    end
  end

  // Next-state logic for the controller and the x/y/z datapath
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cos_d   = cos_q;
    sin_d   = sin_q;
`ifdef CORDIC_VECTOR_EN
    vec_d   = vec_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ROT;
          busy_d  = 1'b1;
          iter_d  = 4'd0;
          x_d     = X0;
          y_d     = {(DW+2){1'b0}};
          neg_d   = quad_s;
          if (quad_s) begin
            z_d = {~theta[15], theta[14:0]};
          end else begin
            z_d = theta;
          end
`ifdef CORDIC_VECTOR_EN
          vec_d = mode;
          if (mode) begin
            neg_d = 1'b0;
            if (x_in[DW-1]) begin
              // left half-plane: rotate by 180 deg so x starts positive
              x_d = -x_ext_s;
              y_d = -y_ext_s;
              z_d = 16'h8000;
            end else begin
              x_d = x_ext_s;
              y_d = y_ext_s;
              z_d = 16'h0000;
            end
          end else begin
            vec_d = 1'b0;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROT: begin
        if (dir_s) begin
          x_d = x_q + y_sh_s;
          y_d = y_q - x_sh_s;
          z_d = z_q + atan_lut(iter_q);
        end else begin
          x_d = x_q - y_sh_s;
          y_d = y_q + x_sh_s;
          z_d = z_q - atan_lut(iter_q);
        end
        if (iter_q == ITER_LAST) begin
          state_d = ST_OUT;
          iter_d  = 4'd0;
        end else begin
          iter_d  = iter_q + 4'd1;
        end
      end
      ST_OUT: begin
        cos_d   = sat_dw(x_fin_s);
`ifdef CORDIC_VECTOR_EN
        if (vec_q) begin
          sin_d = z_to_dw(z_q);
        end else begin
          sin_d = sat_dw(y_fin_s);
        end
`else
        sin_d   = sat_dw(y_fin_s);
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any computation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iter_q  <= 4'd0;
      x_q     <= {(DW+2){1'b0}};
      y_q     <= {(DW+2){1'b0}};
      z_q     <= 16'h0000;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cos_q   <= {DW{1'b0}};
      sin_q   <= {DW{1'b0}};
`ifdef CORDIC_VECTOR_EN
      vec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
`ifdef CORDIC_VECTOR_EN
      vec_q   <= vec_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Directed table-driven bench for cordic_sincos_iter (DW=16, ITER=16).
// Expected trig values are ideal results scaled by 2^14.
module tb_cordic_sincos_iter;

  localparam int DW  = 16;
  localparam int TOL = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   theta = 16'h0000;
  logic          busy;
  logic          done;
  logic [DW-1:0] cos_out;
  logic [DW-1:0] sin_out;
`ifdef CORDIC_VECTOR_EN
  logic          mode = 1'b0;
  logic [DW-1:0] x_in = 16'h0000;
  logic [DW-1:0] y_in = 16'h0000;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  cordic_sincos_iter #(.DW(16), .ITER(16), .X_INIT(9949)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .theta   (theta),
`ifdef CORDIC_VECTOR_EN
    .mode    (mode),
    .x_in    (x_in),
    .y_in    (y_in),
`endif
    .busy    (busy),
    .done    (done),
    .cos_out (cos_out),
    .sin_out (sin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] th;
    int          cos_e;
    int          sin_e;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req, input int tol);
    int diff;
    n_cmp++;
    diff = act - req;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, req, tol);
    end
  endtask

  // Launch one computation and wait for done; lat counts edges including
  // the one that samples start, bcnt counts edges after which busy is high.
  task automatic run_op(input logic [15:0] th, output int lat, output int bcnt);
    @(negedge clk);
    theta = th;
    start = 1'b1;
    lat   = 0;
    bcnt  = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (busy) bcnt++;
    end while (!done && lat < 40);
  endtask

  function automatic int s16(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  initial begin
    vec_t tbl [6];
    int   lat, bcnt, dcnt, first, second;
    logic signed [15:0] wrap;

    tbl[0] = '{16'h0000,  16384,      0};
    tbl[1] = '{16'h2000,  11585,  11585};
    tbl[2] = '{16'hE000,  11585, -11585};
    tbl[3] = '{16'h4000,      0,  16384};
    tbl[4] = '{16'h8000, -16384,      0};
    tbl[5] = '{16'hA000, -11585, -11585};

    // reset state
    #2 rst_n = 1'b0;
    #20;
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_cos", s16(cos_out), 0, 0);
    chk("rst_sin", s16(sin_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // main rotation table
    for (int k = 0; k < 6; k++) begin
      run_op(tbl[k].th, lat, bcnt);
      chk($sformatf("lat[%0d]", k), lat, 18, 0);
      chk($sformatf("busy_cycles[%0d]", k), bcnt, 17, 0);
      chk($sformatf("cos[%0d]", k), s16(cos_out), tbl[k].cos_e, TOL);
      chk($sformatf("sin[%0d]", k), s16(sin_out), tbl[k].sin_e, TOL);
      @(posedge clk);
      #1;
      chk($sformatf("done_pulse[%0d]", k), int'(done), 0, 0);
    end

    // second start while busy is ignored
    @(negedge clk);
    theta = 16'h2000;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat   = 1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      lat++;
    end
    theta = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_ign_lat", lat, 18, 0);
    chk("busy_ign_cos", s16(cos_out), 11585, TOL);
    chk("busy_ign_sin", s16(sin_out), 11585, TOL);
    // outputs hold until the next done
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", int'(done), 0, 0);
    chk("hold_busy", int'(busy), 0, 0);
    chk("hold_cos", s16(cos_out), 11585, TOL);
    chk("hold_sin", s16(sin_out), 11585, TOL);

    // reset in the middle of a computation
    @(negedge clk);
    theta = 16'h4000;
    start = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("abort_busy_pre", int'(busy), 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_done", int'(done), 0, 0);
    chk("abort_cos", s16(cos_out), 0, 0);
    chk("abort_sin", s16(sin_out), 0, 0);
    dcnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'hE000, lat, bcnt);
    chk("after_rst_lat", lat, 18, 0);
    chk("after_rst_cos", s16(cos_out), 11585, TOL);
    chk("after_rst_sin", s16(sin_out), -11585, TOL);

    // start held high re-triggers right after done
    @(negedge clk);
    theta  = 16'h0000;
    start  = 1'b1;
    lat    = 0;
    first  = 0;
    second = 0;
    while (second == 0 && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        if (first == 0) first = lat;
        else second = lat;
      end
    end
    start = 1'b0;
    chk("retrig_first", first, 18, 0);
    chk("retrig_gap", second - first, 18, 0);
    chk("retrig_cos", s16(cos_out), 16384, TOL);

`ifdef CORDIC_VECTOR_EN
    // vectoring: the floor bias of arithmetic shifts pushes the magnitude
    // a few LSB above the ideal gain-scaled value, hence the wider tolerance
    repeat (2) @(posedge clk);
    mode = 1'b1;
    x_in = 16'd8192;
    y_in = 16'd8192;
    run_op(16'h0000, lat, bcnt);
    chk("vec45_lat", lat, 18, 0);
    chk("vec45_ang", s16(sin_out), 8192, TOL);
    chk("vec45_mag", s16(cos_out), 19079, 8);
    x_in = 16'hE000;
    y_in = 16'h0000;
    run_op(16'h0000, lat, bcnt);
    wrap = sin_out - 16'h8000;
    chk("vec180_ang", int'(wrap), 0, TOL);
    chk("vec180_mag", s16(cos_out), 13491, 8);
    mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cordic_sincos_iter.md
Name: cordic_sincos_iter

Overview:
- Parametrised iterative CORDIC, rotation mode: computes cos(theta) and sin(theta) together, one micro-rotation per clock.
- Full-circle angle input, handled by quadrant pre-rotation.
- Signed arithmetic-shift datapath with guard bits and output saturation.
- Sits between the angle/phase generator and DSP consumers, with a start/busy/done handshake.

Parameters:
- DW, 16: signed data width of the cos/sin outputs, format Q2.(DW-2); 1.0 = 2^(DW-2). Range 8..24.
- ITER, 16: number of micro-rotations. Range 8..16.
- X_INIT, 9949: initial x, equal to round(0.607253·2^(DW-2)). Must be recomputed by the instantiator when DW changes.

Ports:
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- start  in  1: request; sampled only in IDLE.
- theta  in  16: angle in binary angle units, signed; 0x4000 = +90°, 0x8000 = -180°.
- busy  out  1: high while a computation is in progress.
- done  out  1: one-cycle pulse when results update.
- cos_out  out  DW: signed cosine result, held until the next done.
- sin_out  out  DW: signed sine result, held until the next done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, cos_out, sin_out, iteration counter, x/y/z all 0.
- A reset mid-computation aborts it: no done pulse, outputs return to 0.

State machine:
- IDLE: if start=1, latch the pre-rotated angle, set x=X_INIT, y=0, i=0, go to ROT. busy goes high the next cycle.
- ROT: performs one micro-rotation per cycle for i = 0..ITER-1. When i = ITER-1, go to OUT.
- OUT: write saturated results to cos_out/sin_out, pulse done for one cycle, clear busy, go to IDLE.
- start is ignored while busy=1.
- start held high re-triggers from IDLE on the cycle after done.

Latency:
- Start sampled at edge N produces done=1 in the cycle after edge N+ITER+1.
- Total: ITER+2 cycles from start to done. Throughput is one result per ITER+2 cycles.

Pre-rotation:
- Define q = theta[15] XOR theta[14] (|theta| > 90°).
- If q=1: z0 = theta with MSB inverted (±180° shift), and the final x,y are negated before saturation.
- If q=0: z0 = theta.
- The negate flag is latched at start.

Datapath:
- x,y are signed DW+2 bits; z is signed 16 bits.
- Direction d = z[15].
- d=0: x -= y>>>i; y += x>>>i; z -= A[i].
- d=1: x += y>>>i; y -= x>>>i; z += A[i].
- Shifts are arithmetic (sign-extending). Updates use the old x,y values simultaneously.

Angle table A[i] (BAM16) for i = 0..15:
- 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.

Output stage:
- Saturate to [-2^(DW-1), 2^(DW-1)-1].
- Negation of -2^(DW+1) is not reachable given X_INIT.

Optional Feature:
- Macro: CORDIC_VECTOR_EN.
- When defined, add ports mode (in, 1), x_in (in, DW) and y_in (in, DW).
- mode=1 at start selects vectoring:
  - Load x=x_in, y=y_in, z=0.
  - If x_in<0: negate x and y, and set z0=0x8000.
  - d = ~y[DW+1] (drive y toward 0); z update follows the same d convention.
  - At OUT: cos_out = saturate(x_final), the magnitude with uncompensated gain ≈1.6468. sin_out = z_final sign-extended or truncated to DW (angle, BAM16 top bits when DW<16). No output negation.
- Inputs with |x_in|,|y_in| ≤ 2^(DW-3) never saturate.
- mode=0 behaves exactly as without the macro.
- When not defined: no extra ports; rotation mode only.

Test Plan:
Expected values use DW=16, ITER=16, X_INIT=9949, with ±4 LSB tolerance.
- Reset then theta=0x0000, start pulse → done exactly 18 cycles later; cos_out≈16384, sin_out≈0; busy high for 17 cycles.
- theta=0x2000 (45°) → cos≈11585, sin≈11585. theta=0xE000 (-45°) → cos≈11585, sin≈-11585.
- theta=0x4000 (90°) → cos≈0, sin≈16384. theta=0x8000 (-180°) → cos≈-16384, sin≈0 (pre-rotation path). theta=0xA000 (-135°) → cos≈-11585, sin≈-11585.
- Second start pulse while busy, with theta=0x4000 → ignored; results match the first request; outputs hold after done until the next done.
- rst_n low 5 cycles after start → busy=0, outputs 0, no done; a new start after release completes normally in 18 cycles.
- CORDIC_VECTOR_EN, mode=1, x_in=8192, y_in=8192 → sin_out≈8192 (45°), cos_out≈19079. x_in=-8192, y_in=0 → sin_out≈-32768 (0x8000), cos_out≈13491.
